ctrl_arr_sched: RTL

CTRL_ARR_SCHED -- requirements
Module: ctrl_arr_sched

---
 rtl/ctrl_arr_pkg.sv | 16 +
 rtl/ctrl_arr_sched_rr_arb.sv | 47 ++++
 rtl/ctrl_arr_sched.sv | 116 +++++++++++
 3 files changed

// File: rtl/ctrl_arr_pkg.sv
// Shared defaults and the tag type carried alongside each word through the
// ctrl_arr latency pipeline.
package ctrl_arr_pkg;

    localparam int NUM_REQ_DEF = 4;
    localparam int DATA_W_DEF  = 32;
    localparam int LAT_DEF     = 4;

    localparam int TAG_ID_W = (NUM_REQ_DEF > 1) ? $clog2(NUM_REQ_DEF) : 1;

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/ctrl_arr_sched_rr_arb.sv
// Round-robin arbiter: the search starts one past the last accepted grant and
// wraps; the pointer moves only when adv reports that the grant was taken.
module rr_arb #(
    parameter int NUM_REQ = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               adv,
    output logic [NUM_REQ-1:0] gnt
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [IDX_W-1:0] last_q;
    logic [IDX_W-1:0] last_d;
    logic [IDX_W-1:0] win_idx;
    logic             found;

    always_comb begin
        int idx;
        idx     = 0;
        gnt     = '0;
        found   = 1'b0;
        win_idx = last_q;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_q) + k) % NUM_REQ;
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                win_idx  = IDX_W'(idx);
            end
        end
    end

    assign last_d = (adv && found) ? win_idx : last_q;

    // Resetting to the last index makes requester 0 the first one searched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= IDX_W'(NUM_REQ - 1);
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/ctrl_arr_sched.sv
// Shares one fixed-latency ctrl_arr datapath among NUM_REQ requesters: one
// word issued per cycle, results routed back to their owner by a tag pipeline.
module ctrl_arr_sched
    import ctrl_arr_pkg::*;
#(
    parameter int  NUM_REQ = NUM_REQ_DEF,
    parameter int  DATA_W  = DATA_W_DEF,
    parameter int  LAT     = LAT_DEF,
    localparam int CNT_W   = $clog2(LAT + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      pause,
    output logic [DATA_W-1:0]         arr_in,
    input  logic [DATA_W-1:0]         arr_out,
    output logic [NUM_REQ-1:0]        resp_valid,
    output logic [DATA_W-1:0]         resp_data,
    output logic                      busy,
    output logic [CNT_W-1:0]          inflight
);

    localparam int ID_W = $bits(tag_t) - 1;

    logic [NUM_REQ-1:0] gnt;
    logic               hs;
    logic [DATA_W-1:0]  sel_data;
    logic [ID_W-1:0]    sel_id;
    tag_t               push_tag;
    tag_t               tag_q [LAT];
    logic               retire;

    logic [DATA_W-1:0]  arr_in_q;
    logic [DATA_W-1:0]  arr_in_d;
    logic [NUM_REQ-1:0] resp_valid_q;
    logic [NUM_REQ-1:0] resp_valid_d;
    logic [CNT_W-1:0]   inflight_q;
    logic [CNT_W-1:0]   inflight_d;

    rr_arb #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk (clk),
        .rst (rst),
        .req (req_valid),
        .adv (hs),
        .gnt (gnt)
    );

    // The grant is only exposed when new words may actually be taken.
    assign req_ready = (rst || pause) ? '0 : gnt;
    assign hs        = |(req_ready & req_valid);

    always_comb begin
        sel_data = '0;
        sel_id   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                sel_data = req_data[i*DATA_W +: DATA_W];
                sel_id   = ID_W'(i);
            end
        end
    end

    always_comb begin
        push_tag       = '0;
        push_tag.valid = hs;
        push_tag.id    = hs ? sel_id : '0;
        arr_in_d       = hs ? sel_data : '0;
    end

    assign retire = tag_q[LAT-1].valid;

    always_comb begin
        inflight_d = inflight_q;
        case ({push_tag.valid, retire})
            2'b10:   inflight_d = inflight_q + CNT_W'(1);
            2'b01:   inflight_d = inflight_q - CNT_W'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    // The last stage is decoded and registered so the flag lines up with the
    // ctrl_arr result for the word issued LAT cycles earlier.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_resp_dec
        assign resp_valid_d[gi] = tag_q[LAT-1].valid && (tag_q[LAT-1].id == ID_W'(gi));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) begin
                tag_q[i] <= '0;
            end
            arr_in_q     <= '0;
            resp_valid_q <= '0;
            inflight_q   <= '0;
        end else begin
            tag_q[0] <= push_tag;
            for (int i = 1; i < LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
            arr_in_q     <= arr_in_d;
            resp_valid_q <= resp_valid_d;
            inflight_q   <= inflight_d;
        end
    end

    assign arr_in     = arr_in_q;
    assign resp_valid = resp_valid_q;
    assign resp_data  = arr_out;
    assign inflight   = inflight_q;
    assign busy       = (inflight_q != '0);

endmodule
